// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller between the core byte bus and the RAM/UART pair.
// Splits accesses into RAM or I/O, buffers UART bytes, provides the cycle counter and stop detection.
module mmio_ctrl #(
  parameter int unsigned TX_DEPTH_LOG = 4,
  parameter int unsigned RX_DEPTH_LOG = 4,
  parameter int unsigned FULL_MARGIN  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic [7:0]  ram_din,
  output logic        ram_we,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        program_finish,
  output logic        tx_overflow
);

  localparam int unsigned TX_DEPTH = 32'd1 << TX_DEPTH_LOG;
  localparam int unsigned RX_DEPTH = 32'd1 << RX_DEPTH_LOG;
  localparam int unsigned TX_PW    = TX_DEPTH_LOG + 1;
  localparam int unsigned RX_PW    = RX_DEPTH_LOG + 1;
  localparam logic [17:0] ADDR_UART = 18'h30000;
  localparam logic [17:0] ADDR_CNT  = 18'h30004;

  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [TX_PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, tx_cnt_nxt;
  logic [RX_PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [31:0]      counter_q, counter_d, snapshot_q, snapshot_d;
  logic             rd_sel_q, rd_sel_d;
  logic [7:0]       io_byte_q, io_byte_d;
  logic             io_buffer_full_q, io_buffer_full_d;
  logic             tx_overflow_q, tx_overflow_d;
  logic             stop_pending_q, stop_pending_d;
  logic             program_finish_q, program_finish_d;

  logic       io_sel, io_rd, io_wr, a_uart, a_cnt, a_cnt_grp;
  logic       tx_empty, tx_full, tx_pop, tx_req, tx_push;
  logic       rx_empty, rx_full, rx_push, rx_pop;
  logic [7:0] tx_head, rx_head, tx_wdata;
  logic       unused_addr_hi;

  assign unused_addr_hi = ^mem_a[31:18];

  // Address decode and bus qualification
  assign io_sel    = (mem_a[17:16] == 2'b11);
  assign io_rd     = rdy_in & ~mem_wr & io_sel;
  assign io_wr     = rdy_in & mem_wr & io_sel;
  assign a_uart    = (mem_a[17:0] == ADDR_UART);
  assign a_cnt     = (mem_a[17:0] == ADDR_CNT);
  assign a_cnt_grp = (mem_a[17:2] == ADDR_CNT[17:2]);
  assign ram_we    = mem_wr & rdy_in & ~io_sel;

  // FIFO status; pointer MSB distinguishes full from empty
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TX_PW-1] != tx_rd_q[TX_PW-1]) &&
                    (tx_wr_q[TX_DEPTH_LOG-1:0] == tx_rd_q[TX_DEPTH_LOG-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RX_PW-1] != rx_rd_q[RX_PW-1]) &&
                    (rx_wr_q[RX_DEPTH_LOG-1:0] == rx_rd_q[RX_DEPTH_LOG-1:0]);
  assign tx_head  = tx_mem_q[tx_rd_q[TX_DEPTH_LOG-1:0]];
  assign rx_head  = rx_mem_q[rx_rd_q[RX_DEPTH_LOG-1:0]];

  assign tx_pop   = ~tx_empty & tx_ready;
  assign tx_req   = io_wr & ((a_uart & (mem_dout != 8'h00)) | a_cnt);
  assign tx_wdata = a_uart ? mem_dout : 8'h00;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts
  assign tx_push  = tx_req & (~tx_full | tx_pop);
  assign rx_push  = rx_valid & ~rx_full;
  assign rx_pop   = io_rd & a_uart & ~rx_empty;

  always_comb begin
    tx_wr_d          = tx_wr_q + TX_PW'(tx_push);
    tx_rd_d          = tx_rd_q + TX_PW'(tx_pop);
    rx_wr_d          = rx_wr_q + RX_PW'(rx_push);
    rx_rd_d          = rx_rd_q + RX_PW'(rx_pop);
    counter_d        = counter_q + 32'd1;
    snapshot_d       = snapshot_q;
    rd_sel_d         = rd_sel_q;
    io_byte_d        = io_byte_q;
    tx_overflow_d    = tx_overflow_q | (tx_req & tx_full & ~tx_pop);
    stop_pending_d   = stop_pending_q | (tx_push & a_cnt);
    program_finish_d = program_finish_q | (stop_pending_q & tx_pop & (tx_head == 8'h00));
    tx_cnt_nxt       = tx_wr_d - tx_rd_d;
    io_buffer_full_d = (TX_DEPTH - 32'(tx_cnt_nxt)) <= FULL_MARGIN;

    // Read path: select and I/O byte are captured for the following cycle
    if (rdy_in && !mem_wr) begin
      rd_sel_d  = io_sel;
      io_byte_d = 8'h00;
      if (io_sel && a_uart) begin
        io_byte_d = rx_empty ? 8'h00 : rx_head;
      end else if (io_sel && a_cnt_grp) begin
        unique case (mem_a[1:0])
          2'd0: begin
            io_byte_d  = counter_q[7:0];
            snapshot_d = counter_q;
          end
          2'd1:    io_byte_d = snapshot_q[15:8];
          2'd2:    io_byte_d = snapshot_q[23:16];
          default: io_byte_d = snapshot_q[31:24];
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_wr_q          <= '0;
      tx_rd_q          <= '0;
      rx_wr_q          <= '0;
      rx_rd_q          <= '0;
      counter_q        <= '0;
      snapshot_q       <= '0;
      rd_sel_q         <= 1'b0;
      io_byte_q        <= 8'h00;
      io_buffer_full_q <= 1'b0;
      tx_overflow_q    <= 1'b0;
      stop_pending_q   <= 1'b0;
      program_finish_q <= 1'b0;
    end else begin
      tx_wr_q          <= tx_wr_d;
      tx_rd_q          <= tx_rd_d;
      rx_wr_q          <= rx_wr_d;
      rx_rd_q          <= rx_rd_d;
      counter_q        <= counter_d;
      snapshot_q       <= snapshot_d;
      rd_sel_q         <= rd_sel_d;
      io_byte_q        <= io_byte_d;
      io_buffer_full_q <= io_buffer_full_d;
      tx_overflow_q    <= tx_overflow_d;
      stop_pending_q   <= stop_pending_d;
      program_finish_q <= program_finish_d;
    end
  end

  // FIFO storage needs no reset; pointers define validity
  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem_q[tx_wr_q[TX_DEPTH_LOG-1:0]] <= tx_wdata;
    if (rx_push) rx_mem_q[rx_wr_q[RX_DEPTH_LOG-1:0]] <= rx_data;
  end

  assign mem_din        = rd_sel_q ? io_byte_q : ram_din;
  assign tx_valid       = ~tx_empty;
  assign tx_data        = tx_empty ? 8'h00 : tx_head;
  assign rx_ready       = ~rx_full;
  assign io_buffer_full = io_buffer_full_q;
  assign tx_overflow    = tx_overflow_q;
  assign program_finish = program_finish_q;

endmodule
